// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: holds the PLL in reset, waits for a synchronized lock,
// qualifies it for a stable window, then releases downstream reset and watches for lock loss.
module pll_reset_ctrl #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             relock_req,
  output logic             pll_resetb,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam int MAX_HW  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_HW > STABLE_CYCLES) ? MAX_HW : STABLE_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  // Terminal values of the shared cycle counter for each timed state.
  localparam logic [CYC_W-1:0] HOLD_LAST    = CYC_W'(HOLD_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             lock_s_q, lock_s_d;
  logic [1:0]       state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can infer a latch.
    sync1_d       = pll_lock;
    lock_s_d      = sync1_q;
    state_d       = state_q;
    cyc_d         = cyc_q;
    timeout_cnt_d = timeout_cnt_q;
    loss_cnt_d    = loss_cnt_q;

    case (state_q)
      ST_HOLD: begin
        if (cyc_q == HOLD_LAST) begin
          state_d = ST_WAIT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_WAIT: begin
        // Lock is checked before the timeout so a lock arriving on the last cycle wins.
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cyc_d   = '0;
        end else if (cyc_q == TIMEOUT_LAST) begin
          state_d = ST_HOLD;
          cyc_d   = '0;
          if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
          cyc_d   = '0;
        end else if (cyc_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_RUN: begin
        // A lost lock takes priority over a relock request arriving in the same cycle.
        if (!lock_s_q) begin
          state_d = ST_HOLD;
          cyc_d   = '0;
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end else if (relock_req) begin
          state_d = ST_HOLD;
          cyc_d   = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cyc_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change together with state_q.
    pll_resetb_d = (state_d != ST_HOLD);
    sys_rst_d    = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= ST_HOLD;
      cyc_q         <= '0;
      timeout_cnt_q <= '0;
      loss_cnt_q    <= '0;
      pll_resetb_q  <= 1'b0;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q       <= sync1_d;
      lock_s_q      <= lock_s_d;
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      timeout_cnt_q <= timeout_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign timeout_cnt = timeout_cnt_q;
  assign loss_cnt    = loss_cnt_q;

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL: parameter HOLD_CYCLES, default 16, number of cycles PLL reset is held asserted per attempt (>=1).
REQ-002 SHALL: parameter LOCK_TIMEOUT, default 4096, cycles allowed in WAIT_LOCK before a retry (>=2).
REQ-003 SHALL: parameter STABLE_CYCLES, default 256, consecutive synchronized-lock-high cycles required before release (>=1).
REQ-004 SHALL: parameter CNT_W, default 8, width of the diagnostic counters.
REQ-005 SHALL: clock  input  1  reference clock; all logic is in this single domain.
REQ-006 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL: pll_lock  input  1  raw PLL LOCK, asynchronous to clock.
REQ-008 SHALL: relock_req  input  1  single-cycle request to force a PLL re-lock.
REQ-009 SHALL: pll_resetb  output  1  drives PLL RESETB, active low.
REQ-010 SHALL: sys_rst  output  1  active-high reset to downstream logic.
REQ-011 SHALL: ready  output  1  high only in RUN.
REQ-012 SHALL: state  output  2  HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3.
REQ-013 SHALL: timeout_cnt  output  CNT_W  count of lock timeouts.
REQ-014 SHALL: loss_cnt  output  CNT_W  count of lock losses while in RUN.

Function
REQ-015 SHALL: synchronize pll_lock through two flops (lock_s); the FSM uses only lock_s.
REQ-016 SHALL: keep all outputs registered; pll_resetb=0 only in HOLD; sys_rst=1 in every state except RUN; ready=1 only in RUN.
REQ-017 SHALL: HOLD lasts exactly HOLD_CYCLES cycles, then goes to WAIT_LOCK with the shared cycle counter cleared.
REQ-018 SHALL: WAIT_LOCK with lock_s=1 goes to STABLE next cycle with the counter cleared.
REQ-019 SHALL: WAIT_LOCK with lock_s=0 for LOCK_TIMEOUT cycles goes to HOLD and increments timeout_cnt.
REQ-020 SHALL: if lock_s rises on the timeout cycle, lock wins: go to STABLE, no timeout counted.
REQ-021 SHALL: STABLE with lock_s=0 on any cycle returns to WAIT_LOCK with the counter cleared; no counter increments.
REQ-022 SHALL: STABLE goes to RUN after lock_s=1 for STABLE_CYCLES consecutive cycles.
REQ-023 SHALL: in RUN, lock_s=0 goes to HOLD next cycle, increments loss_cnt, and asserts sys_rst in that same cycle.
REQ-024 SHALL: in RUN, relock_req=1 with lock_s=1 goes to HOLD with no counter change.
REQ-025 SHALL: if relock_req=1 and lock_s=0 in the same RUN cycle, treat it as a lock loss (loss_cnt increments once).
REQ-026 SHALL: ignore relock_req outside RUN.
REQ-027 SHALL: saturate timeout_cnt and loss_cnt at 2^CNT_W-1, with no wrap.
REQ-028 SHALL: size the cycle counter to hold max(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Reset
REQ-029 SHALL: while reset=1, state=HOLD, counter=0, sync flops=0, pll_resetb=0, sys_rst=1, ready=0, timeout_cnt=0, loss_cnt=0.
REQ-030 SHALL: reset asserted mid-operation (any state) forces the REQ-029 values immediately and asynchronously.
REQ-031 SHALL: after reset deasserts, HOLD runs a full HOLD_CYCLES sequence.

Verification (HOLD_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_W=8)
REQ-032 SHALL: Nominal: pll_lock=1 from 10 cycles after reset -> pll_resetb low exactly 4 cycles; RUN and sys_rst=0 reached; ready=1; counters 0.
REQ-033 SHALL: Timeout: pll_lock=0 throughout -> HOLD/WAIT_LOCK loop with period 36 cycles; timeout_cnt counts 1,2,3..., saturates at 255, never wraps.
REQ-034 SHALL: Glitch in STABLE: lock drops for 1 cycle after 5 stable cycles -> back to WAIT_LOCK; RUN needs 8 fresh consecutive cycles; no counter change.
REQ-035 SHALL: Loss in RUN: lock drops -> sys_rst=1, ready=0, state=HOLD one cycle after lock_s falls; loss_cnt=1; relock completes once lock returns.
REQ-036 SHALL: relock_req: a pulse in RUN -> HOLD, loss_cnt unchanged; pulses in WAIT_LOCK/STABLE have no effect; relock_req with lock_s low in RUN -> loss_cnt +1 exactly.
REQ-037 SHALL: Async reset: reset asserted mid-STABLE for 1 cycle, not clock-aligned -> all outputs hit reset values without a clock edge; full sequence restarts.
